chan_irq_tx: RTL
================

Name: chan_irq_tx

Overview:
- Channel-side interrupt transmitter for the system bus.
- Latches interrupt events raised by up to 16 devices on one I/O channel and arbitrates for the bus.
- Presents each interrupt to the CPU interrupt unit as a channel interrupt (`rin` + `rdt`).
- Completes on `dok`. Backs off and retries when the CPU answers `en` (busy/reject).

Parameters:
- RETRY_TICKS, 64: clk_sys cycles spent in BACKOFF after an `en` reject before re-arbitrating (1..65535).
- TIMEOUT_TICKS, 1024: clk_sys cycles allowed in SEND without `dok`/`en` (used only with CHAN_IRQ_TIMEOUT_EN).

Ports:
- clk_sys  in  1  system clock; the only clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  1  device interrupt event strobe, one cycle.
- req_num  in  4  device number for req.
- zg  out  1  bus request to arbiter.
- zw  in  1  bus grant; level, held while zg is held.
- rin  out  1  interrupt request on system bus.
- rdt  out  [0:15]  bus data: rdt[11:14] = device number, all other bits 0; all-zero when not in SEND (wired-OR bus).
- dok  in  1  CPU accepted the interrupt.
- en  in  1  CPU rejected/busy.
- pending  out  16  pending-interrupt vector, bit i = device i.
- busy  out  1  FSM not in IDLE.
- tmo_err  out  1  sticky timeout flag (CHAN_IRQ_TIMEOUT_EN only, else tied 0).

Behaviour:
- Reset values: all outputs 0, pending = 0, state IDLE, counters 0.
- Assertion of rst_n low clears everything immediately, including mid-SEND. rin, zg and rdt drop asynchronously.
- Pending set:
  - req at edge n sets pending[req_num] visible at n+1.
  - A req for an already-pending bit merges (no count).
- Selection:
  - Lowest-numbered pending bit wins.
  - The number is latched into `cur` on IDLE->ARB and held until return to IDLE or BACKOFF.
- FSM:
  - IDLE: if pending != 0, go to ARB; zg=1 from the next cycle.
  - ARB: zg=1; on zw=1, go to SEND.
  - SEND: zg=1, rin=1, rdt[11:14]=cur.
    - On dok=1: clear pending[cur], go to RELEASE.
    - On en=1 (dok=0): go to BACKOFF.
    - If dok and en are both 1, dok wins.
  - RELEASE: rin=0, zg=1; wait until dok=0 and en=0, then go to IDLE with zg=0.
  - BACKOFF: rin=0, zg=0; count RETRY_TICKS cycles, then go to IDLE (re-selects, so a higher-priority arrival overtakes).
- Simultaneous req for cur with dok in SEND: set wins; the bit stays pending and is resent later.
- Minimum latency: req at n -> zg at n+2 -> with zw already high, rin at n+3.
- zw dropping during SEND: abandon the attempt. Go to IDLE without clearing pending; rin=0 next cycle.
- busy = (state != IDLE).
- Counters saturate; no wrap.

Optional Feature:
- Macro: CHAN_IRQ_TIMEOUT_EN.
- Defined:
  - Counter runs in SEND.
  - After TIMEOUT_TICKS cycles with no dok/en: clear pending[cur], set tmo_err=1 (sticky until reset), go to RELEASE.
- Undefined:
  - SEND waits indefinitely.
  - No timeout counter is built; tmo_err is constant 0.

Test Plan:
- Single request: req, req_num=5, zw tied 1, dok pulsed 2 cycles after rin -> rin at n+3, rdt=0x000A (rdt[11:14]=0101), pending[5] clears, return to IDLE, zg=0.
- Priority: req 9 then req 3 in consecutive cycles while IDLE -> first SEND carries 3 (rdt=0x0006), second carries 9 (rdt=0x0012).
- Reject: en=1 in SEND with RETRY_TICKS=4 -> rin falls next cycle, zg low for 4 cycles, re-arbitration; pending bit kept until a later dok.
- Same-bit collision: req_num=cur coincident with dok -> pending[cur] remains 1 and the interrupt is resent once more.
- Async reset mid-SEND: rst_n low while rin=1 -> rin, zg, rdt, pending all 0 without a clock edge.
- CHAN_IRQ_TIMEOUT_EN with TIMEOUT_TICKS=8, no response -> after 8 cycles in SEND: tmo_err=1, pending[cur]=0, FSM to RELEASE then IDLE.

Source files
------------

// File: rtl/chan_irq_tx_if.sv
// chan_irq_tx_if: system-bus signals between a channel interrupt
// transmitter (master) and the bus arbiter / CPU interrupt unit (slave).
// zg/zw are the bus request/grant pair; rin/rdt carry the interrupt and
// dok/en are the CPU's accept/reject answers.
interface chan_irq_tx_if;
    logic        zg;
    logic        zw;
    logic        rin;
    logic [0:15] rdt;
    logic        dok;
    logic        en;

    modport master (output zg, rin, rdt, input zw, dok, en);
    modport slave  (input zg, rin, rdt, output zw, dok, en);
endinterface

// File: rtl/chan_irq_tx.sv
// chan_irq_tx: latches device interrupt events of one I/O channel, picks the
// lowest-numbered pending device, arbitrates for the system bus and presents
// it to the CPU as rin + rdt. Completes on dok, backs off on en.
// Optional build macro: CHAN_IRQ_TIMEOUT_EN adds a SEND timeout and the
// sticky tmo_err flag; without it SEND waits indefinitely and tmo_err is 0.
module chan_irq_tx #(
    parameter int RETRY_TICKS   = 64,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          req,
    input  logic [3:0]    req_num,
    chan_irq_tx_if.master bus,
    output logic [15:0]   pending,
    output logic          busy,
    output logic          tmo_err
);

    if (RETRY_TICKS < 1 || RETRY_TICKS > 65535 ||
        TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 65535) begin : g_param_check
        $error("chan_irq_tx: RETRY_TICKS/TIMEOUT_TICKS must be in 1..65535");
    end

    localparam logic [15:0] RETRY_LAST = 16'(RETRY_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        SEND,
        RELEASE,
        BACKOFF
    } state_t;

    state_t      state;
    logic [3:0]  cur;
    logic [15:0] cnt;
    logic [15:0] set_vec;
    logic [15:0] clr_vec;
    logic [15:0] next_pend;
    logic [3:0]  sel;
    logic        tmo_hit;

    // Counters hold at full scale instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Bus frame: device number in rdt[11:14], everything else zero.
    function automatic logic [0:15] frame(input logic [3:0] n);
        logic [0:15] r;
        r        = '0;
        r[11:14] = n;
        return r;
    endfunction

    // Pending update: a new event on the same edge as a clear wins, so an
    // interrupt raised while its predecessor is being accepted is not lost.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (req) set_vec[req_num] = 1'b1;
        if (state == SEND && (bus.dok || tmo_hit)) clr_vec[cur] = 1'b1;
        next_pend = (pending & ~clr_vec) | set_vec;
    end

    // Lowest-numbered bit wins; selecting from next_pend lets an event that
    // arrives on the IDLE->ARB edge still take priority.
    always_comb begin
        sel = '0;
        for (int i = 15; i >= 0; i--) begin
            if (next_pend[i]) sel = 4'(i);
        end
    end

`ifdef CHAN_IRQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_TICKS - 1);

    // Timeout fires only when no other SEND exit applies this cycle.
    always_comb begin
        tmo_hit = (state == SEND) && !bus.dok && !bus.en && bus.zw &&
                  (cnt == TMO_LAST);
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)       tmo_err <= 1'b0;
        else if (tmo_hit) tmo_err <= 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_err = 1'b0;
`endif

    // Pending-interrupt vector.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= next_pend;
    end

    // Transmit FSM with registered bus outputs.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur     <= '0;
            cnt     <= '0;
            bus.zg  <= 1'b0;
            bus.rin <= 1'b0;
            bus.rdt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pending != '0) begin
                        state  <= ARB;
                        cur    <= sel;
                        bus.zg <= 1'b1;
                    end
                end
                ARB: begin
                    if (bus.zw) begin
                        state   <= SEND;
                        cnt     <= '0;
                        bus.rin <= 1'b1;
                        bus.rdt <= frame(cur);
                    end
                end
                SEND: begin
                    if (bus.dok) begin
                        state   <= RELEASE;
                        bus.rin <= 1'b0;
                        bus.rdt <= '0;
                    end else if (bus.en) begin
                        state   <= BACKOFF;
                        cnt     <= '0;
                        bus.zg  <= 1'b0;
                        bus.rin <= 1'b0;
                        bus.rdt <= '0;
                    end else if (!bus.zw) begin
                        state   <= IDLE;
                        bus.zg  <= 1'b0;
                        bus.rin <= 1'b0;
                        bus.rdt <= '0;
                    end else if (tmo_hit) begin
                        state   <= RELEASE;
                        bus.rin <= 1'b0;
                        bus.rdt <= '0;
                    end
`ifdef CHAN_IRQ_TIMEOUT_EN
                    else begin
                        cnt <= sat_inc(cnt);
                    end
`endif
                end
                RELEASE: begin
                    if (!bus.dok && !bus.en) begin
                        state  <= IDLE;
                        bus.zg <= 1'b0;
                    end
                end
                BACKOFF: begin
                    if (cnt >= RETRY_LAST) state <= IDLE;
                    else                   cnt   <= sat_inc(cnt);
                end
                default: begin
                    state   <= IDLE;
                    bus.zg  <= 1'b0;
                    bus.rin <= 1'b0;
                    bus.rdt <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
